// File: rtl/ram_burst_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM burst arbiter.
package ram_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int DEF_LEN_WIDTH = 3;

  // Round-robin pick: the pointer only decides a tie.
  function automatic logic pick(input logic [1:0] req, input logic ptr);
    if (req == 2'b11) return ptr;
    return req[1] ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/ram_burst_arbiter_if.sv
// Requester-side bus of the RAM burst arbiter: two burst request ports plus shared read data.
interface ram_burst_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);
  logic                  req0,   req1;
  logic                  we0,    we1;
  logic [ADDR_WIDTH-1:0] addr0,  addr1;
  logic [LEN_WIDTH-1:0]  len0,   len1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  gnt0,   gnt1;
  logic                  beat0,  beat1;
  logic                  done0,  done1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1,
    input  gnt0, gnt1, beat0, beat1, done0, done1, rvalid0, rvalid1, rdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1,
    output gnt0, gnt1, beat0, beat1, done0, done1, rvalid0, rvalid1, rdata, busy
  );
endinterface

// File: rtl/ram_burst_arbiter_ram.sv
// Single-port RAM with registered read address: data for a read at cycle t appears in t+1.
module one_port_RAM #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data_in;
    addr_q <= addr;
  end

  assign data_out = mem[addr_q];
endmodule

// File: rtl/ram_burst_arbiter.sv
// Round-robin arbiter and burst sequencer for two requesters sharing one_port_RAM.
// All outputs are registered: the gnt cycle is the arbitration cycle, beats follow back to back.
module ram_burst_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  ram_burst_arbiter_if.slave bus
);
  logic [1:0]                 req, we_in;
  logic [1:0][ADDR_WIDTH-1:0] addr_in;
  logic [1:0][LEN_WIDTH-1:0]  len_in;
  logic [1:0][DATA_WIDTH-1:0] wdata_in;

  assign req      = {bus.req1,   bus.req0};
  assign we_in    = {bus.we1,    bus.we0};
  assign addr_in  = {bus.addr1,  bus.addr0};
  assign len_in   = {bus.len1,   bus.len0};
  assign wdata_in = {bus.wdata1, bus.wdata0};

  state_t                state;
  logic                  ptr, id, we_l, nxt;
  logic [ADDR_WIDTH-1:0] base, ram_addr;
  logic [LEN_WIDTH-1:0]  len_l, cnt;
  logic [1:0]            gnt, beat, done, rvalid;
  logic                  ram_wr, busy;
  logic [DATA_WIDTH-1:0] ram_dout;

  assign nxt = pick(req, ptr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= REQ0;
      id       <= REQ0;
      we_l     <= 1'b0;
      base     <= '0;
      len_l    <= '0;
      cnt      <= '0;
      gnt      <= '0;
      beat     <= '0;
      done     <= '0;
      rvalid   <= '0;
      ram_addr <= '0;
      ram_wr   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      gnt    <= '0;
      beat   <= '0;
      done   <= '0;
      // ram_wr/beat describe the beat in flight; its read data lands next cycle.
      rvalid <= beat & {2{~ram_wr}};
      case (state)
        IDLE: begin
          if (|req) begin
            gnt[nxt] <= 1'b1;
            id       <= nxt;
            we_l     <= we_in[nxt];
            base     <= addr_in[nxt];
            len_l    <= len_in[nxt];
            cnt      <= '0;
            ptr      <= ~nxt;
            busy     <= 1'b1;
            state    <= BURST;
          end else begin
            busy <= 1'b0;
          end
        end
        BURST: begin
          beat[id] <= 1'b1;
          ram_addr <= base + ADDR_WIDTH'(cnt);
          ram_wr   <= we_l;
          busy     <= 1'b1;
          if (cnt == len_l) begin
            done[id] <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // rst_n gates the write so a write beat cut short by reset never lands.
  one_port_RAM #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk      (clk),
    .we       (rst_n & ram_wr & (|beat)),
    .addr     (ram_addr),
    .data_in  (wdata_in[id]),
    .data_out (ram_dout)
  );

  assign bus.gnt0    = gnt[0];
  assign bus.gnt1    = gnt[1];
  assign bus.beat0   = beat[0];
  assign bus.beat1   = beat[1];
  assign bus.done0   = done[0];
  assign bus.done1   = done[1];
  assign bus.rvalid0 = rvalid[0];
  assign bus.rvalid1 = rvalid[1];
  assign bus.rdata   = ram_dout;
  assign bus.busy    = busy;
endmodule
